// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: frame state encoding and frame-geometry helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a. Contents: serial_state_t, frame_cycles(), ctr_width().
package serial_pkg;

   // Frame phases, in transmission order. A matching receiver walks the same sequence.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } serial_state_t;

   // Total cycles of one frame: start + data + optional parity + stop, each one bit long.
   function automatic int frame_cycles(input int width, input int clks_per_bit, input int parity_en);
      return (2 + width + parity_en) * clks_per_bit;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int ctr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ShiftRegisterPIPO.sv
// Parallel-in/parallel-out shift register: parallel load, or one-place right shift toward Q[0].
// Latency: one cycle from i_load/i_shift to o_q.
// Backpressure: none; load takes priority over shift. Ports: clock, reset_L, i_load, i_shift, i_d, o_q.
module ShiftRegisterPIPO #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_L,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_shift) begin
         r_q <= {1'b0, r_q[WIDTH-1:1]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/serial_transmitter.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Latency: line goes low the cycle after accept; frame lasts (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: ready is high only in IDLE; data_valid while busy is dropped, not queued.
// Ports: clock, reset_L (sync, active low), data/data_valid/ready handshake, serial_out, busy, done.
module serial_transmitter
   import serial_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clock,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data,
   input  logic             data_valid,
   output logic             ready,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int TW = ctr_width(CLKS_PER_BIT);
   localparam int IW = ctr_width(WIDTH);
   localparam logic [TW-1:0] LP_BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LP_IDX_LAST = IW'(WIDTH - 1);

   serial_state_t    r_state;
   serial_state_t    w_state_nxt;
   logic [TW-1:0]    r_timer;
   logic [TW-1:0]    w_timer_nxt;
   logic [IW-1:0]    r_index;
   logic [IW-1:0]    w_index_nxt;
   logic             r_parity;
   logic             r_serial_out;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_bit_wrap;
   logic             w_shift;
   logic             w_serial_nxt;
   logic             w_ready_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [WIDTH-1:0] w_q;

   // Q[0] always holds the next data bit to go out: the bit is copied into the output
   // register and the shifter advances on the same edge that opens each data bit.
   ShiftRegisterPIPO #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clock   (clock),
      .reset_L (reset_L),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_d     (data),
      .o_q     (w_q)
   );

   // Next-state, counters and next output values.
   always_comb begin
      w_state_nxt  = r_state;
      w_index_nxt  = r_index;
      w_shift      = 1'b0;
      w_serial_nxt = 1'b1;
      w_ready_nxt  = 1'b0;
      w_busy_nxt   = 1'b1;
      w_done_nxt   = 1'b0;

      w_accept   = r_ready && data_valid;
      w_bit_wrap = (r_timer == LP_BIT_LAST);

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_wrap) begin
               w_state_nxt = ST_DATA;
               w_shift     = 1'b1;
            end
         end
         ST_DATA: begin
            if (w_bit_wrap) begin
               if (r_index == LP_IDX_LAST) begin
                  w_index_nxt = '0;
                  w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  w_index_nxt = r_index + 1'b1;
                  w_shift     = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_wrap) begin
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_bit_wrap) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // The bit timer idles at zero and restarts at every bit boundary.
      w_timer_nxt = ((r_state == ST_IDLE) || w_bit_wrap) ? '0 : r_timer + 1'b1;

      // Outputs are decoded from the state being entered so they can be registered.
      case (w_state_nxt)
         ST_IDLE: begin
            w_serial_nxt = 1'b1;
            w_ready_nxt  = 1'b1;
            w_busy_nxt   = 1'b0;
         end
         ST_START: begin
            w_serial_nxt = 1'b0;
         end
         ST_DATA: begin
            w_serial_nxt = w_shift ? w_q[0] : r_serial_out;
         end
         ST_PARITY: begin
            w_serial_nxt = r_parity;
         end
         ST_STOP: begin
            w_serial_nxt = 1'b1;
            w_done_nxt   = (w_timer_nxt == LP_BIT_LAST);
         end
         default: begin
            w_serial_nxt = 1'b1;
            w_ready_nxt  = 1'b1;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_L) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_index <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_index <= w_index_nxt;
      end
   end

   // Registered outputs and the parity captured with the word.
   always_ff @(posedge clock) begin
      if (!reset_L) begin
         r_serial_out <= 1'b1;
         r_ready      <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_parity     <= 1'b0;
      end else begin
         r_serial_out <= w_serial_nxt;
         r_ready      <= w_ready_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         if (w_accept) begin
            r_parity <= ^data;
         end
      end
   end

   assign serial_out = r_serial_out;
   assign ready      = r_ready;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three instances (parity on, parity off, one clock per bit).
// Each frame is compared cycle by cycle against the frame derived from the word itself.
// Ports of every instance are driven from the single directed sequence below.
module tb_serial_transmitter;

   logic            clock;
   logic            reset_L;
   logic [2:0][7:0] dat;
   logic [2:0]      dv;
   logic [2:0]      rdy;
   logic [2:0]      so;
   logic [2:0]      bsy;
   logic [2:0]      dn;

   int checks = 0;
   int errors = 0;

   serial_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u0 (
      .clock(clock), .reset_L(reset_L), .data(dat[0]), .data_valid(dv[0]),
      .ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0]));

   serial_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u1 (
      .clock(clock), .reset_L(reset_L), .data(dat[1]), .data_valid(dv[1]),
      .ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1]));

   serial_transmitter #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u2 (
      .clock(clock), .reset_L(reset_L), .data(dat[2]), .data_valid(dv[2]),
      .ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]), .done(dn[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int k);
      chk({tag, "_ready"},  k, 32'(rdy[k]), 32'd1);
      chk({tag, "_busy"},   k, 32'(bsy[k]), 32'd0);
      chk({tag, "_serial"}, k, 32'(so[k]),  32'd1);
      chk({tag, "_done"},   k, 32'(dn[k]),  32'd0);
   endtask

   // Send one word from IDLE and check every cycle of the frame plus the idle cycle after it.
   // keep=1 leaves data_valid high with random data through the frame and the idle cycle.
   task automatic run_frame(input int k, input logic [7:0] word, input int cpb, input int par,
                            input bit keep);
      int       n;
      int       slot;
      logic     exp_bit;
      logic [7:0] rec;
      n   = (2 + 8 + par) * cpb;
      rec = 8'h00;
      chk("pre_ready", k, 32'(rdy[k]), 32'd1);
      dv[k]  = 1'b1;
      dat[k] = word;
      tick();
      for (int c = 1; c <= n; c++) begin
         dv[k]  = keep;
         dat[k] = 8'($urandom);
         slot   = (c - 1) / cpb;
         if (slot == 0)                   exp_bit = 1'b0;
         else if (slot <= 8)              exp_bit = word[slot-1];
         else if (par != 0 && slot == 9)  exp_bit = ^word;
         else                             exp_bit = 1'b1;
         chk("serial", k, 32'(so[k]),  32'(exp_bit));
         chk("busy",   k, 32'(bsy[k]), 32'd1);
         chk("ready",  k, 32'(rdy[k]), 32'd0);
         chk("done",   k, 32'(dn[k]),  32'(c == n));
         // Receiver-style recovery: sample each data bit in its middle.
         if (slot >= 1 && slot <= 8 && ((c - 1) % cpb) == (cpb / 2)) begin
            rec[slot-1] = so[k];
         end
         tick();
      end
      chk_idle("gap", k);
      chk("loopback", k, 32'(rec), 32'(word));
   endtask

   initial begin
      reset_L = 1'b0;
      dv      = '0;
      dat     = '0;
      tick();
      tick();
      for (int k = 0; k < 3; k++) chk_idle("reset", k);
      reset_L = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) chk_idle("post_reset", k);

      // Worked example frame, and a word whose parity bit is 1.
      run_frame(0, 8'hA5, 4, 1, 1'b0);
      run_frame(0, 8'h01, 4, 1, 1'b0);

      // No parity slot: 40-cycle frame.
      run_frame(1, 8'h01, 4, 0, 1'b0);

      // data_valid held high with changing data: second word taken only after the gap.
      run_frame(0, 8'h5A, 4, 1, 1'b1);
      run_frame(0, 8'hC3, 4, 1, 1'b0);

      // Reset during data bit 3, then a clean frame.
      dv[0]  = 1'b1;
      dat[0] = 8'hA5;
      tick();
      dv[0] = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      chk("mid_busy", 0, 32'(bsy[0]), 32'd1);
      reset_L = 1'b0;
      tick();
      chk_idle("mid_reset", 0);
      // An accept attempt while reset is held must not start a frame.
      dv[0]  = 1'b1;
      dat[0] = 8'h99;
      tick();
      chk_idle("reset_hold", 0);
      reset_L = 1'b1;
      dv[0]   = 1'b0;
      tick();
      chk_idle("reset_release", 0);
      run_frame(0, 8'h3C, 4, 1, 1'b0);

      // One clock per bit, back to back: 11-cycle frames, one idle cycle apart.
      run_frame(2, 8'hFF, 1, 1, 1'b0);
      run_frame(2, 8'h00, 1, 1, 1'b0);

      // Random words on every instance.
      for (int i = 0; i < 100; i++) begin
         run_frame(0, 8'($urandom), 4, 1, (i < 99) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         run_frame(1, 8'($urandom), 4, 0, 1'b0);
         run_frame(2, 8'($urandom), 1, 1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per frame (WIDTH SHALL be >= 2).
REQ-002 Parameter: CLKS_PER_BIT, 4, clock cycles per serial bit (CLKS_PER_BIT SHALL be >= 1).
REQ-003 Parameter: PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-004 Port: clock  input  1  sole clock; all state SHALL update on posedge clock.
REQ-005 Port: reset_L  input  1  synchronous, active-low reset.
REQ-006 Port: data  input  WIDTH  parallel word to transmit.
REQ-007 Port: data_valid  input  1  requester has a word on data.
REQ-008 Port: ready  output  1  transmitter can accept a word this cycle.
REQ-009 Port: serial_out  output  1  serial line; idle level is 1.
REQ-010 Port: busy  output  1  a frame is in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE: ready=1, busy=0, serial_out=1, done=0.
REQ-014 Accept occurs on the posedge where data_valid=1 and ready=1; data SHALL be latched and the state SHALL go to START.
REQ-015 data_valid with ready=0 SHALL be ignored and not queued; data changes after accept SHALL have no effect on the frame.
REQ-016 START SHALL drive serial_out=0 for CLKS_PER_BIT cycles, beginning the cycle after accept.
REQ-017 DATA SHALL drive the WIDTH latched bits LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-018 PARITY (only if PARITY_EN=1) SHALL drive the XOR of all latched bits for CLKS_PER_BIT cycles; if PARITY_EN=0, DATA SHALL go directly to STOP.
REQ-019 STOP SHALL drive serial_out=1 for CLKS_PER_BIT cycles; done=1 in the last of these cycles only; the next state SHALL be IDLE.
REQ-020 Frame length SHALL be (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles; busy=1 and ready=0 for every cycle from START through STOP.
REQ-021 The minimum gap between frames SHALL be one IDLE cycle, giving back-to-back accepts every frame length +1 cycles.
REQ-022 The bit-timer SHALL count 0..CLKS_PER_BIT-1 and wrap; its width is max(1,$clog2(CLKS_PER_BIT)); when CLKS_PER_BIT=1 every cycle is a bit boundary.
REQ-023 The data-bit index SHALL count 0..WIDTH-1; leaving DATA SHALL occur on the bit-timer wrap at index WIDTH-1.
REQ-024 All outputs SHALL be registered (glitch-free serial_out).

Reset
REQ-025 reset_L=0 at a posedge SHALL force IDLE, serial_out=1, ready=1, busy=0, done=0, and bit-timer and index =0, mid-frame included; the frame is abandoned.
REQ-026 Accept SHALL NOT occur on a posedge where reset_L=0.

Structure
REQ-027 The state enum typedef SHALL live in shared package serial_pkg, for reuse by a future matching receiver.
REQ-028 Data shifting SHALL use one instance of the library ShiftRegisterPIPO (load on accept, right shift at each data-bit boundary, serial_out sourced from Q[0]).

Verification (WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
REQ-029 Accept 0xA5 -> serial_out sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1; 44 cycles; done pulses at cycle 44.
REQ-030 Accept 0x01 -> parity bit =1; with PARITY_EN=0 the frame is 40 cycles with no parity slot.
REQ-031 Hold data_valid=1 with data changing mid-frame -> first frame unaffected; second word accepted only in the IDLE cycle after done.
REQ-032 Deassert reset_L for one cycle during DATA bit 3 -> serial_out=1, ready=1 on the next posedge; a new accept of 0x3C then yields a clean frame.
REQ-033 CLKS_PER_BIT=1, words 0xFF then 0x00 back-to-back -> 11-cycle frames separated by exactly one idle cycle.
REQ-034 Loopback into ShiftRegisterSIPO sampling mid-bit, 100 random words -> every recovered word equals the sent word.
